lif_sweep_scheduler: RTL and testbench

//  Time-multiplexes one shared LIF membrane-update core across N_NEURONS neurons.
//  On each 1 ms tick strobe it sweeps neuron indices 0..N_NEURONS-1 in order:
//  - issues one update request per neuron;
//  - writes back the returned membrane value;
//  - tracks per-neuron refractory periods;
//  - publishes the sweep's spike vector.

---
 rtl/lif_sweep_scheduler_if.sv | 26 ++
 rtl/lif_sweep_scheduler.sv | 140 ++++++++++++++
 tb/tb_lif_sweep_scheduler.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lif_sweep_scheduler_if.sv
// Request/response channel between the sweep scheduler and the shared LIF core.
// master = scheduler side, slave = LIF core side.
interface lif_sweep_scheduler_if #(
  parameter int IDX_W = 2,
  parameter int V_W   = 8,
  parameter int I_W   = 8
) ();
  logic             req_valid;
  logic             req_ready;
  logic [IDX_W-1:0] req_idx;
  logic [V_W-1:0]   req_v;
  logic [I_W-1:0]   req_i;
  logic             rsp_valid;
  logic [V_W-1:0]   rsp_v;
  logic             rsp_spike;

  modport master (
    output req_valid, req_idx, req_v, req_i,
    input  req_ready, rsp_valid, rsp_v, rsp_spike
  );

  modport slave (
    input  req_valid, req_idx, req_v, req_i,
    output req_ready, rsp_valid, rsp_v, rsp_spike
  );
endinterface

// File: rtl/lif_sweep_scheduler.sv
// Sweeps all neurons through one shared LIF core per tick, keeping membrane
// state, refractory counters and the per-sweep spike vector.
module lif_sweep_scheduler #(
  parameter int N_NEURONS    = 4,
  parameter int IDX_W        = 2,
  parameter int V_W          = 8,
  parameter int I_W          = 8,
  parameter int REFRAC_TICKS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic                     en,
  input  logic [N_NEURONS*I_W-1:0] i_in,
  lif_sweep_scheduler_if.master    core,
  output logic [N_NEURONS-1:0]     spike_out,
  output logic                     sweep_done,
  output logic                     busy,
  output logic                     overrun
);

  localparam int RW =
    (REFRAC_TICKS > 0) ? $clog2(REFRAC_TICKS + 1) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_NEURONS - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    SKIP,
    DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [V_W-1:0]           v_q [N_NEURONS];
  logic [V_W-1:0]           v_d [N_NEURONS];
  logic [RW-1:0]            refrac_q [N_NEURONS];
  logic [RW-1:0]            refrac_d [N_NEURONS];
  logic [N_NEURONS*I_W-1:0] snap_q, snap_d;
  logic [N_NEURONS-1:0]     spk_q, spk_d;
  logic [N_NEURONS-1:0]     spike_out_q, spike_out_d;
  logic                     sweep_done_q, sweep_done_d;
  logic                     overrun_q, overrun_d;
  logic                     adv;
  logic [IDX_W-1:0]         nxt_idx;
  logic                     issuing;

  assign nxt_idx = idx_q + IDX_W'(1);
  assign issuing = (state_q == ISSUE);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    v_d          = v_q;
    refrac_d     = refrac_q;
    snap_d       = snap_q;
    spk_d        = spk_q;
    spike_out_d  = spike_out_q;
    sweep_done_d = 1'b0;
    overrun_d    = overrun_q | (tick & (state_q != IDLE));
    adv          = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tick && en) begin
          snap_d  = i_in;
          idx_d   = '0;
          state_d = (refrac_q[0] != '0) ? SKIP : ISSUE;
        end
      end
      ISSUE: begin
        if (core.req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (core.rsp_valid) begin
          v_d[idx_q]   = core.rsp_spike ? '0 : core.rsp_v;
          spk_d[idx_q] = core.rsp_spike;
          if (core.rsp_spike) refrac_d[idx_q] = RW'(REFRAC_TICKS);
          adv = 1'b1;
        end
      end
      SKIP: begin
        refrac_d[idx_q] = refrac_q[idx_q] - RW'(1);
        spk_d[idx_q]    = 1'b0;
        adv             = 1'b1;
      end
      DONE: begin
        spike_out_d  = spk_q;
        sweep_done_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Next neuron's refractory count is untouched this cycle, so q is exact.
    if (adv) begin
      if (idx_q == LAST) begin
        state_d = DONE;
      end else begin
        idx_d   = nxt_idx;
        state_d = (refrac_q[nxt_idx] != '0) ? SKIP : ISSUE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      v_q          <= '{default: '0};
      refrac_q     <= '{default: '0};
      snap_q       <= '0;
      spk_q        <= '0;
      spike_out_q  <= '0;
      sweep_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      v_q          <= v_d;
      refrac_q     <= refrac_d;
      snap_q       <= snap_d;
      spk_q        <= spk_d;
      spike_out_q  <= spike_out_d;
      sweep_done_q <= sweep_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign core.req_valid = issuing;
  assign core.req_idx   = issuing ? idx_q : '0;
  assign core.req_v     = issuing ? v_q[idx_q] : '0;
  assign core.req_i     =
    issuing ? snap_q[int'(idx_q)*I_W +: I_W] : '0;

  assign spike_out  = spike_out_q;
  assign sweep_done = sweep_done_q;
  assign busy       = (state_q != IDLE);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_lif_sweep_scheduler.sv
// Bench for lif_sweep_scheduler: table of sweeps plus stall, overrun and
// mid-sweep reset sequences, with a request/spike scoreboard.
module tb_lif_sweep_scheduler;
  localparam int N = 4, IDX_W = 2, V_W = 8, I_W = 8, RT = 3;

  logic clk = 1'b0;
  logic rst, tick, en;
  logic [N*I_W-1:0] i_in;
  logic [N-1:0] spike_out;
  logic sweep_done, busy, overrun;

  lif_sweep_scheduler_if #(.IDX_W(IDX_W), .V_W(V_W), .I_W(I_W)) core_if ();

  lif_sweep_scheduler #(
    .N_NEURONS(N), .IDX_W(IDX_W), .V_W(V_W), .I_W(I_W), .REFRAC_TICKS(RT)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .en(en), .i_in(i_in),
    .core(core_if), .spike_out(spike_out), .sweep_done(sweep_done),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic [V_W-1:0]   v;
    logic [I_W-1:0]   i;
  } req_t;

  typedef struct {
    logic [N-1:0]     mask;
    logic [N*I_W-1:0] iv;
    logic [N-1:0]     exp_spk;
    int               exp_cyc;
  } vec_t;

  req_t         exp_req_q[$];
  logic [N-1:0] exp_spk_q[$];
  int errors = 0, checks = 0;

  logic [N-1:0]   mask = '0;
  logic [V_W-1:0] v_m [N];
  int             ref_m [N];
  logic           pend = 1'b0, pend_s = 1'b0, late_rsp = 1'b0, accepted = 1'b0;
  logic [V_W-1:0] pend_v = '0;
  int             stall_left = 0;
  logic [IDX_W-1:0] stall_idx = '0;
  logic           stall_first = 1'b0;
  logic [V_W-1:0] stall_v = '0;
  logic [I_W-1:0] stall_i = '0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      v_m[k] = '0;
      ref_m[k] = 0;
    end
    exp_req_q.delete();
    exp_spk_q.delete();
    pend = 1'b0;
  endtask

  // Reference of one sweep: expected request stream, spike vector, duration.
  task automatic model_sweep(input logic [N*I_W-1:0] iv, output int exp_cyc);
    logic [N-1:0] s;
    logic [I_W-1:0] cur;
    s = '0;
    exp_cyc = 2;
    for (int k = 0; k < N; k++) begin
      cur = iv[k*I_W +: I_W];
      if (ref_m[k] > 0) begin
        ref_m[k]--;
        exp_cyc += 1;
      end else begin
        exp_req_q.push_back('{idx: IDX_W'(k), v: v_m[k], i: cur});
        exp_cyc += 2;
        if (mask[k]) begin
          s[k] = 1'b1;
          v_m[k] = '0;
          ref_m[k] = RT;
        end else begin
          v_m[k] = v_m[k] + cur;
        end
      end
    end
    exp_spk_q.push_back(s);
  endtask

  // One clock: core responder, request scoreboard, sweep_done scoreboard.
  task automatic step();
    req_t r;
    @(negedge clk);
    core_if.rsp_valid = pend | late_rsp;
    core_if.rsp_v     = late_rsp ? 8'hAA : pend_v;
    core_if.rsp_spike = late_rsp ? 1'b1 : pend_s;
    pend = 1'b0;
    late_rsp = 1'b0;
    accepted = 1'b0;
    if (core_if.req_valid === 1'b1 && stall_left > 0 &&
        core_if.req_idx == stall_idx) begin
      if (stall_first) begin
        stall_v = core_if.req_v;
        stall_i = core_if.req_i;
        stall_first = 1'b0;
      end
      chk("stall_hold",
          {core_if.req_valid, core_if.req_idx, core_if.req_v, core_if.req_i},
          {1'b1, stall_idx, stall_v, stall_i});
      core_if.req_ready = 1'b0;
      stall_left--;
    end else begin
      core_if.req_ready = 1'b1;
    end
    if (core_if.req_valid === 1'b1 && core_if.req_ready) begin
      accepted = 1'b1;
      if (exp_req_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL req_unexpected: got idx %0d expected none",
                 core_if.req_idx);
      end else begin
        r = exp_req_q.pop_front();
        chk("req", {core_if.req_idx, core_if.req_v, core_if.req_i},
            {r.idx, r.v, r.i});
      end
      pend   = 1'b1;
      pend_v = core_if.req_v + core_if.req_i;
      pend_s = mask[core_if.req_idx];
    end
    if (sweep_done === 1'b1) begin
      if (exp_spk_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sweep_done_unexpected: got 1 expected 0");
      end else begin
        chk("spike_out_sb", spike_out, exp_spk_q.pop_front());
      end
    end
  endtask

  task automatic run_sweep(input logic [N-1:0] m, input logic [N*I_W-1:0] iv,
                           input bit extra, output int cyc, output int exp_cyc);
    mask = m;
    i_in = iv;
    model_sweep(iv, exp_cyc);
    tick = 1'b1;
    for (cyc = 1; cyc <= 100; cyc++) begin
      step();
      tick = (extra && cyc == 3);
      if (sweep_done === 1'b1) break;
    end
    tick = 1'b0;
    chk("req_q_drained", exp_req_q.size(), 0);
  endtask

  vec_t tbl [7];
  int cyc, exp_cyc, n;
  bit seen;

  initial begin
    rst = 1'b1;
    tick = 1'b0;
    en = 1'b0;
    i_in = '0;
    core_if.req_ready = 1'b1;
    core_if.rsp_valid = 1'b0;
    core_if.rsp_v = '0;
    core_if.rsp_spike = 1'b0;
    model_clear();

    tbl[0] = '{4'b0000, 32'h04030201, 4'b0000, 10};
    tbl[1] = '{4'b0100, 32'h04030201, 4'b0100, 10};
    tbl[2] = '{4'b0000, 32'h04030201, 4'b0000, 9};
    tbl[3] = '{4'b0100, 32'h10203040, 4'b0000, 9};
    tbl[4] = '{4'b0000, 32'h04030201, 4'b0000, 9};
    tbl[5] = '{4'b0001, 32'h05060708, 4'b0001, 10};
    tbl[6] = '{4'b1001, 32'h01010101, 4'b1000, 9};

    step();
    step();
    chk("reset_outputs",
        {core_if.req_valid, core_if.req_idx, core_if.req_v, core_if.req_i,
         spike_out, sweep_done, busy, overrun}, '0);
    rst = 1'b0;
    en = 1'b1;
    step();

    foreach (tbl[t]) begin
      run_sweep(tbl[t].mask, tbl[t].iv, 1'b0, cyc, exp_cyc);
      chk($sformatf("tbl%0d_cycles", t), cyc, tbl[t].exp_cyc);
      chk($sformatf("tbl%0d_spike_out", t), spike_out, tbl[t].exp_spk);
      step();
    end

    stall_idx = 2'd1;
    stall_left = 5;
    stall_first = 1'b1;
    run_sweep(4'b0000, 32'h09080706, 1'b0, cyc, exp_cyc);
    chk("stall_cycles", cyc, exp_cyc + 5);
    chk("stall_consumed", stall_left, 0);
    chk("overrun_quiet", overrun, 1'b0);
    step();

    run_sweep(4'b0000, 32'h01020304, 1'b1, cyc, exp_cyc);
    chk("overrun_cycles", cyc, exp_cyc);
    chk("overrun_set", overrun, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (busy !== 1'b0 || core_if.req_valid !== 1'b0) seen = 1'b1;
    end
    chk("no_second_sweep", seen, 1'b0);

    en = 1'b0;
    tick = 1'b1;
    step();
    tick = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (busy !== 1'b0 || core_if.req_valid !== 1'b0) seen = 1'b1;
    end
    chk("tick_en0_ignored", seen, 1'b0);
    chk("overrun_sticky", overrun, 1'b1);

    en = 1'b1;
    mask = '0;
    i_in = 32'h11111111;
    model_sweep(i_in, exp_cyc);
    tick = 1'b1;
    n = 0;
    do begin
      step();
      tick = 1'b0;
      n++;
    end while (!accepted && n < 20);
    chk("reset_wait_reached", accepted, 1'b1);
    step();
    rst = 1'b1;
    model_clear();
    step();
    rst = 1'b0;
    chk("reset_mid_outputs",
        {core_if.req_valid, spike_out, sweep_done, busy, overrun}, '0);
    late_rsp = 1'b1;
    step();
    step();
    chk("late_rsp_ignored", {busy, core_if.req_valid, sweep_done}, '0);

    run_sweep(4'b0010, 32'h0A0B0C0D, 1'b0, cyc, exp_cyc);
    chk("post_reset_cycles", cyc, 10);
    chk("post_reset_spike_out", spike_out, 4'b0010);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
